// File: rtl/pam4_slicer_ber.sv
// pam4_slicer_ber: PAM4 slicer with windowed symbol-error counter.
// Slices each strobed sample into a 2-bit symbol, compares it against a
// delayed copy of the transmitted reference, and counts mismatches over a
// window of WINDOW_LEN symbols under a small IDLE/FILL/MEASURE/DONE FSM.
// Optional feature macro: PAM4_SLICER_ERRMAG_EN enables the accumulator of
// slicing-error magnitude on err_mag_acc; when undefined the port reads 0.

// Combinational 4-level decision for one lane.
module pam4_slicer_dec #(
  parameter int THRESH = 87381
) (
  input  logic [17:0] x,
  output logic [1:0]  sym
);
  localparam logic signed [18:0] THR_P = 19'(THRESH);
  localparam logic signed [18:0] THR_N = -THR_P;

  logic signed [18:0] xs;
  assign xs = {x[17], x};

  // Outer/inner decision boundaries at -THRESH, 0, +THRESH
  always_comb begin
    sym = 2'b11;
    if (xs < THR_N)           sym = 2'b00;
    else if (xs < 19'sd0)     sym = 2'b01;
    else if (xs < THR_P)      sym = 2'b10;
    else                      sym = 2'b11;
  end
endmodule

module pam4_slicer_ber #(
  parameter int REF_DELAY  = 10,
  parameter int WINDOW_LEN = 1024,
  parameter int THRESH     = 87381
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic [17:0] x_in,
  input  logic [1:0]  ref_sym,
  input  logic        start,
  output logic [1:0]  sym_out,
  output logic        sym_valid,
  output logic [15:0] err_count,
  output logic [15:0] sym_count,
  output logic        busy,
  output logic        done,
  output logic [31:0] err_mag_acc
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_MEASURE, S_DONE} state_t;

  localparam logic [4:0]  FILL_MAX = 5'(REF_DELAY);
  localparam logic [15:0] WIN_LAST = 16'(WINDOW_LEN - 1);

  state_t      state_q, state_d;
  logic        clear_cnt;
  logic [1:0]  sym_dec;
  logic [1:0]  ref_cmp;
  logic [4:0]  fill_cnt;
  logic        mismatch;
  logic        count_en;

  // ---------------------------------------------------------------------
  // Slicer: runs on every strobe regardless of FSM state
  // ---------------------------------------------------------------------
  pam4_slicer_dec #(.THRESH(THRESH)) u_dec (
    .x   (x_in),
    .sym (sym_dec)
  );

  // Register decision; sym_valid pulses the clk after each strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_out   <= 2'b00;
      sym_valid <= 1'b0;
    end else begin
      sym_valid <= clk_en;
      if (clk_en) sym_out <= sym_dec;
    end
  end

  // ---------------------------------------------------------------------
  // Reference delay line: shifts on every strobe in all states so the
  // alignment to the receive path never depends on FSM history.
  // ---------------------------------------------------------------------
  generate
    if (REF_DELAY == 0) begin : g_nodly
      assign ref_cmp = ref_sym;
    end else begin : g_dly
      logic [REF_DELAY-1:0][1:0] dly;

      // Tap 0 holds the newest reference, tap REF_DELAY-1 the oldest
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dly <= '0;
        end else if (clk_en) begin
          dly[0] <= ref_sym;
          for (int i = 1; i < REF_DELAY; i++) dly[i] <= dly[i-1];
        end
      end

      assign ref_cmp = dly[REF_DELAY-1];
    end
  endgenerate

  // Fill counter: strobes seen since reset, saturating once the delay
  // line holds valid history
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             fill_cnt <= 5'd0;
    else if (clk_en && fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + 5'd1;
  end

  // ---------------------------------------------------------------------
  // Window FSM
  // ---------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; start clears the counters on the same edge it is accepted
  always_comb begin
    state_d   = state_q;
    clear_cnt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FILL;
          clear_cnt = 1'b1;
        end
      end
      S_FILL: begin
        if (fill_cnt == FILL_MAX) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (clk_en && sym_count == WIN_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_d   = S_FILL;
          clear_cnt = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q == S_FILL) || (state_q == S_MEASURE);
  assign done     = (state_q == S_DONE);
  assign count_en = (state_q == S_MEASURE) && clk_en;
  assign mismatch = (sym_dec != ref_cmp);

  // Window counters; error count sticks at all-ones instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_count <= 16'd0;
      err_count <= 16'd0;
    end else if (clear_cnt) begin
      sym_count <= 16'd0;
      err_count <= 16'd0;
    end else if (count_en) begin
      sym_count <= sym_count + 16'd1;
      if (mismatch && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Optional slicing-error magnitude accumulator
  // ---------------------------------------------------------------------
`ifdef PAM4_SLICER_ERRMAG_EN
  logic signed [19:0] lvl;
  logic signed [19:0] diff;
  logic        [19:0] mag;
  logic        [32:0] acc_sum;
  logic        [31:0] acc_q;

  // Ideal level of the decided symbol and distance of the sample from it
  always_comb begin
    lvl = 20'sd131071;
    case (sym_dec)
      2'b00:   lvl = -20'sd131072;
      2'b01:   lvl = -20'sd43691;
      2'b10:   lvl = 20'sd43690;
      default: lvl = 20'sd131071;
    endcase
    diff    = {{2{x_in[17]}}, x_in} - lvl;
    mag     = diff[19] ? 20'(-diff) : diff;
    acc_sum = {1'b0, acc_q} + {13'd0, mag};
  end

  // Accumulate during MEASURE, saturating at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          acc_q <= 32'd0;
    else if (clear_cnt) acc_q <= 32'd0;
    else if (count_en)  acc_q <= acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
  end

  assign err_mag_acc = acc_q;
`else
  assign err_mag_acc = 32'd0;
`endif

endmodule
